// File: rtl/nn_layer_sequencer_pkg.sv
// Shared definitions for the NN layer sequencer: FSM states and the fixed
// word addresses of the network description table.
package nn_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_NUM,
        LT_NUM,
        RD_IN,
        LT_IN,
        RD_LYR,
        LT_LYR,
        ISSUE,
        RUN,
        DONE
    } state_t;

    localparam int NUM_LAYERS_ADDR = 0;
    localparam int INPUT_ADDR      = 1;
    localparam int LAYER_BASE      = 2;

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Signal bundle between the layer sequencer, its control/host side, the
// description table and the neuron control unit.
interface nn_layer_sequencer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 6
);
    logic                  start;
    logic                  abort;
    logic                  host_wr_ena;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_data;
    logic                  host_ack;
    logic                  tbl_wr_ena;
    logic [ADDR_WIDTH-1:0] tbl_addr;
    logic [DATA_WIDTH-1:0] tbl_data_in;
    logic [DATA_WIDTH-1:0] tbl_rd_data;
    logic                  layer_valid;
    logic                  layer_ready;
    logic [IDX_WIDTH-1:0]  layer_idx;
    logic [DATA_WIDTH-1:0] layer_inputs;
    logic [DATA_WIDTH-1:0] layer_neurons;
    logic                  layer_done;
    logic                  busy;
    logic                  done;
    logic                  cfg_error;

    modport master (
        input  start, abort, host_wr_ena, host_addr, host_data,
               tbl_rd_data, layer_ready, layer_done,
        output host_ack, tbl_wr_ena, tbl_addr, tbl_data_in,
               layer_valid, layer_idx, layer_inputs, layer_neurons,
               busy, done, cfg_error
    );

    modport slave (
        output start, abort, host_wr_ena, host_addr, host_data,
               tbl_rd_data, layer_ready, layer_done,
        input  host_ack, tbl_wr_ena, tbl_addr, tbl_data_in,
               layer_valid, layer_idx, layer_inputs, layer_neurons,
               busy, done, cfg_error
    );

endinterface

// File: rtl/nn_desc_port_mux.sv
// Table port arbitration: the host owns the port while the sequencer is idle,
// otherwise the sequencer drives read addresses and host writes are dropped.
module nn_desc_port_mux #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  idle,
    input  logic                  host_wr_ena,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
    input  logic [ADDR_WIDTH-1:0] seq_addr,
    output logic                  tbl_wr_ena,
    output logic [ADDR_WIDTH-1:0] tbl_addr,
    output logic [DATA_WIDTH-1:0] tbl_data_in,
    output logic                  host_ack
);

    assign tbl_wr_ena  = idle & host_wr_ena;
    assign host_ack    = idle & host_wr_ena;
    assign tbl_addr    = idle ? host_addr : seq_addr;
    assign tbl_data_in = idle ? host_data : '0;

endmodule

// File: rtl/nn_layer_sequencer.sv
// Walks the NN description table layer by layer and hands each layer's
// configuration to the neuron control unit, waiting for completion in between.
module nn_layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LAYERS = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    nn_layer_sequencer_if.master bus
);

    localparam int IDX_WIDTH = $clog2(MAX_LAYERS);
    // One extra bit so "index reached layer count" works when L == MAX_LAYERS.
    localparam int CNT_WIDTH = IDX_WIDTH + 1;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] num_layers_reg;
    logic [DATA_WIDTH-1:0] inputs_reg;
    logic [DATA_WIDTH-1:0] neurons_reg;
    logic [CNT_WIDTH-1:0]  idx_reg;
    logic                  cfg_error_reg;

    logic [CNT_WIDTH-1:0]  idx_inc;
    logic                  idx_last;
    logic [ADDR_WIDTH-1:0] seq_addr;

    assign idx_inc  = idx_reg + 1'b1;
    assign idx_last = (DATA_WIDTH'(idx_inc) == num_layers_reg);

    always_comb begin
        seq_addr = '0;
        case (state_reg)
            RD_NUM:  seq_addr = ADDR_WIDTH'(NUM_LAYERS_ADDR);
            RD_IN:   seq_addr = ADDR_WIDTH'(INPUT_ADDR);
            RD_LYR:  seq_addr = ADDR_WIDTH'(LAYER_BASE) + ADDR_WIDTH'(idx_reg);
            default: seq_addr = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            num_layers_reg <= '0;
            inputs_reg     <= '0;
            neurons_reg    <= '0;
            idx_reg        <= '0;
            cfg_error_reg  <= 1'b0;
        end else if (bus.abort) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg     <= RD_NUM;
                        cfg_error_reg <= 1'b0;
                        idx_reg       <= '0;
                    end
                end
                RD_NUM: state_reg <= LT_NUM;
                LT_NUM: begin
                    num_layers_reg <= bus.tbl_rd_data;
                    if (bus.tbl_rd_data == '0) begin
                        state_reg <= DONE;
                    end else if (bus.tbl_rd_data > DATA_WIDTH'(MAX_LAYERS)) begin
                        cfg_error_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        state_reg <= RD_IN;
                    end
                end
                RD_IN: state_reg <= LT_IN;
                LT_IN: begin
                    inputs_reg <= bus.tbl_rd_data;
                    state_reg  <= RD_LYR;
                end
                RD_LYR: state_reg <= LT_LYR;
                LT_LYR: begin
                    neurons_reg <= bus.tbl_rd_data;
                    // An empty layer is skipped; the next layer keeps the same input count.
                    if (bus.tbl_rd_data == '0) begin
                        idx_reg   <= idx_inc;
                        state_reg <= idx_last ? DONE : RD_LYR;
                    end else begin
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.layer_ready) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (bus.layer_done) begin
                        inputs_reg <= neurons_reg;
                        idx_reg    <= idx_inc;
                        state_reg  <= idx_last ? DONE : RD_LYR;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy          = (state_reg != IDLE);
    assign bus.done          = (state_reg == DONE);
    assign bus.layer_valid   = (state_reg == ISSUE);
    assign bus.layer_idx     = idx_reg[IDX_WIDTH-1:0];
    assign bus.layer_inputs  = inputs_reg;
    assign bus.layer_neurons = neurons_reg;
    assign bus.cfg_error     = cfg_error_reg;

    nn_desc_port_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_port_mux (
        .idle        (state_reg == IDLE),
        .host_wr_ena (bus.host_wr_ena),
        .host_addr   (bus.host_addr),
        .host_data   (bus.host_data),
        .seq_addr    (seq_addr),
        .tbl_wr_ena  (bus.tbl_wr_ena),
        .tbl_addr    (bus.tbl_addr),
        .tbl_data_in (bus.tbl_data_in),
        .host_ack    (bus.host_ack)
    );

endmodule
